// File: rtl/data_types.sv
// Shared datapath types for the out-of-order core: machine word, reservation
// station tag (with its NO_VAL sentinel) and the branch redirect FSM states.
// No ports; imported by the modules that need these types.
package data_types;

  typedef logic [31:0] word32_t;

  localparam int unsigned TAG_W = 4;
  typedef logic [TAG_W-1:0] rs_tag_t;

  // All-ones tag never names a real unit; it marks "no tag held".
  localparam rs_tag_t NO_VAL = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } redirect_state_t;

endpackage

// File: rtl/br_redirect.sv
// Branch mispredict redirect: static not-taken prediction; taken result -> flush, then redirect fetch.
// Latency: flush_o from the cycle after accept for FLUSH_CYCLES cycles, redirect_valid_o FLUSH_CYCLES+1 after accept.
// Backpressure: br_ready_o low outside IDLE (results dropped); redirect held until fetch_ready_i.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   br_valid_i/_taken_i   branch ALU result and its resolved direction
//   br_target_i/_tag_i    resolved target PC and issuing branch unit tag
//   br_ready_o            result accepted this cycle (IDLE only, combinational)
//   flush_o, stall_o      squash speculative state / hold issue and dispatch
//   redirect_valid_o/_pc_o, fetch_ready_i   valid/ready redirect towards fetch
//   last_tag_o            tag of the most recent mispredicting branch
//   mispredict_cnt_o      saturating mispredict count
module br_redirect
  import data_types::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             br_valid_i,
  input  logic             br_taken_i,
  input  word32_t          br_target_i,
  input  rs_tag_t          br_tag_i,
  output logic             br_ready_o,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output word32_t          redirect_pc_o,
  input  logic             fetch_ready_i,
  output logic             stall_o,
  output rs_tag_t          last_tag_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  // Counter is loaded with FLUSH_CYCLES-1 and FLUSH exits when it reads 0,
  // giving exactly FLUSH_CYCLES cycles in FLUSH.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  redirect_state_t state, state_nxt;
  logic [3:0]      flush_cnt, flush_cnt_nxt;
  logic            accept_mispredict;

  assign br_ready_o = (state == IDLE);

  always_comb begin
    state_nxt         = state;
    flush_cnt_nxt     = flush_cnt;
    accept_mispredict = 1'b0;
    case (state)
      IDLE: begin
        // Not-taken results match the prediction and need no action.
        if (br_valid_i && br_taken_i) begin
          accept_mispredict = 1'b1;
          state_nxt         = FLUSH;
          flush_cnt_nxt     = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (flush_cnt == 4'd0) begin
          state_nxt = REDIRECT;
        end else begin
          flush_cnt_nxt = flush_cnt - 4'd1;
        end
      end
      REDIRECT: begin
        if (fetch_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register without any combinational path to the ports.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      flush_cnt        <= 4'd0;
      flush_o          <= 1'b0;
      stall_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      last_tag_o       <= NO_VAL;
      mispredict_cnt_o <= '0;
    end else begin
      state            <= state_nxt;
      flush_cnt        <= flush_cnt_nxt;
      flush_o          <= (state_nxt == FLUSH);
      stall_o          <= (state_nxt != IDLE);
      redirect_valid_o <= (state_nxt == REDIRECT);
      if (accept_mispredict) begin
        redirect_pc_o <= {br_target_i[31:2], 2'b00};
        last_tag_o    <= br_tag_i;
        if (mispredict_cnt_o != {CNT_W{1'b1}}) begin
          mispredict_cnt_o <= mispredict_cnt_o + 1'b1;
        end
      end
    end
  end

endmodule
